// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: initiator-side controller for the rPLL dynamic-divider interface.
// Accepts new divider settings over a valid/ready request and range-checks them.
// It then runs the PLL reset / apply / relock sequence with a lock timeout.
// It runs from the PLL reference clock, so it keeps working while the PLL is unlocked.
//
// Ports:
//   clk, nrst                      reference clock, async active-low reset
//   req_valid/req_ready            new-setting handshake (ready only in IDLE)
//   req_idiv_m1, req_fbdiv_m1      input / feedback divider minus one
//   req_odiv                       output divider value (2,4,8,16..128)
//   done, err                      one-cycle completion / failure pulses
//   err_code                       01 invalid request, 10 lock timeout
//   locked, lock_lost, lock_lost_clr  qualified lock status, sticky loss flag + clear
//   pll_reset, pll_idsel, pll_fbdsel, pll_odsel  drive the PLL
//   pll_lock                       PLL LOCK, asynchronous to clk
module pll_dyn_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOCK_FILTER  = 4,
  parameter int unsigned IDIV_INIT    = 0,
  parameter int unsigned FBDIV_INIT   = 10,
  parameter int unsigned ODIV_INIT    = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_idiv_m1,
  input  logic [5:0] req_fbdiv_m1,
  input  logic [7:0] req_odiv,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       locked,
  output logic       lock_lost,
  input  logic       lock_lost_clr,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  input  logic       pll_lock
);

  localparam int unsigned RST_CNT_W = $clog2(RST_CYCLES);
  localparam int unsigned TMO_W     = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned FILT_W    = $clog2(LOCK_FILTER + 1);

  localparam logic [5:0] IDSEL_INIT  = ~6'(IDIV_INIT);
  localparam logic [5:0] FBDSEL_INIT = ~6'(FBDIV_INIT);
  localparam logic [5:0] ODSEL_INIT  = 6'((64 - ODIV_INIT / 2) % 64);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_INVALID = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOLD_RST  = 2'd1,
    ST_WAIT_LOCK = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [FILT_W-1:0]    filt_q, filt_d;
  logic                 lock_meta_q, lock_sync_q;

  logic       req_ready_q, req_ready_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [1:0] err_code_q, err_code_d;
  logic       locked_q, locked_d;
  logic       lock_lost_q, lock_lost_d;
  logic       pll_reset_q, pll_reset_d;
  logic [5:0] idsel_q, idsel_d;
  logic [5:0] fbdsel_q, fbdsel_d;
  logic [5:0] odsel_q, odsel_d;

  logic       accept_c;
  logic       odiv_ok_c;
  logic [5:0] odsel_req_c;
  logic       lock_ok_c;
  logic       lost_set_c;

  // Legal output divider values
  always_comb begin
    case (req_odiv)
      8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd48,
      8'd64, 8'd80, 8'd96, 8'd112, 8'd128: odiv_ok_c = 1'b1;
      default:                              odiv_ok_c = 1'b0;
    endcase
  end

  // odsel = (64 - odiv/2) mod 64; the 7-bit difference drops its MSB
  assign odsel_req_c = 6'(7'd64 - 7'(req_odiv >> 1));

  assign accept_c = req_valid && req_ready_q;

  // Saturating run-length filter on the synchronized lock
  assign filt_d = !lock_sync_q                      ? '0 :
                  (filt_q == FILT_W'(LOCK_FILTER))  ? filt_q :
                                                      filt_q + FILT_W'(1);

  // Lock qualifies on the LOCK_FILTER-th consecutive high sample
  assign lock_ok_c = lock_sync_q && (filt_q >= FILT_W'(LOCK_FILTER - 1));

  // Sequencer next-state and output logic
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    tmo_d       = tmo_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    locked_d    = locked_q;
    pll_reset_d = pll_reset_q;
    idsel_d     = idsel_q;
    fbdsel_d    = fbdsel_q;
    odsel_d     = odsel_q;
    lost_set_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (locked_q && !lock_sync_q) begin
          locked_d   = 1'b0;
          lost_set_c = 1'b1;
        end
        if (accept_c) begin
          if (odiv_ok_c) begin
            idsel_d     = ~req_idiv_m1;
            fbdsel_d    = ~req_fbdiv_m1;
            odsel_d     = odsel_req_c;
            pll_reset_d = 1'b1;
            locked_d    = 1'b0;
            err_code_d  = ERR_NONE;
            rst_cnt_d   = '0;
            state_d     = ST_HOLD_RST;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_INVALID;
          end
        end
      end

      ST_HOLD_RST: begin
        if (rst_cnt_q == RST_CNT_W'(RST_CYCLES - 1)) begin
          pll_reset_d = 1'b0;
          tmo_d       = '0;
          state_d     = ST_WAIT_LOCK;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        // Lock takes priority over a simultaneous timeout
        if (lock_ok_c) begin
          locked_d = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (tmo_q >= TMO_W'(LOCK_TIMEOUT - 1)) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          locked_d   = 1'b0;
          tmo_d      = TMO_W'(LOCK_TIMEOUT);
          state_d    = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A new loss beats a simultaneous clear
    lock_lost_d = lost_set_c ? 1'b1 : (lock_lost_clr ? 1'b0 : lock_lost_q);

    req_ready_d = (state_d == ST_IDLE) && !accept_c;
  end

  // State and output registers; reset restarts the power-up lock sequence
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_HOLD_RST;
      rst_cnt_q   <= '0;
      tmo_q       <= '0;
      filt_q      <= '0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      req_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      pll_reset_q <= 1'b1;
      idsel_q     <= IDSEL_INIT;
      fbdsel_q    <= FBDSEL_INIT;
      odsel_q     <= ODSEL_INIT;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      tmo_q       <= tmo_d;
      filt_q      <= filt_d;
      lock_meta_q <= pll_lock;
      lock_sync_q <= lock_meta_q;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
      pll_reset_q <= pll_reset_d;
      idsel_q     <= idsel_d;
      fbdsel_q    <= fbdsel_d;
      odsel_q     <= odsel_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign locked     = locked_q;
  assign lock_lost  = lock_lost_q;
  assign pll_reset  = pll_reset_q;
  assign pll_idsel  = idsel_q;
  assign pll_fbdsel = fbdsel_q;
  assign pll_odsel  = odsel_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// tb_pll_dyn_ctrl: randomized self-checking bench for pll_dyn_ctrl.
// A transaction-level model predicts select encodings, reset length and lock/timeout outcome.
module tb_pll_dyn_ctrl;

  localparam int TMO      = 200;
  localparam int RST_LEN  = 16;
  localparam int LOCK_LAT = 2 + 4;

  logic       clk = 1'b0;
  logic       nrst;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_idiv_m1;
  logic [5:0] req_fbdiv_m1;
  logic [7:0] req_odiv;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       locked;
  logic       lock_lost;
  logic       lock_lost_clr;
  logic       pll_reset;
  logic [5:0] pll_idsel;
  logic [5:0] pll_fbdsel;
  logic [5:0] pll_odsel;
  logic       pll_lock;

  int n_chk = 0;
  int n_err = 0;

  // Expected steady IDLE-visible state
  int m_idsel, m_fbdsel, m_odsel, m_err_code, m_locked;

  int valid_od [11] = '{2, 4, 8, 16, 32, 48, 64, 80, 96, 112, 128};

  pll_dyn_ctrl #(.LOCK_TIMEOUT(TMO)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_idiv_m1(req_idiv_m1), .req_fbdiv_m1(req_fbdiv_m1), .req_odiv(req_odiv),
    .done(done), .err(err), .err_code(err_code),
    .locked(locked), .lock_lost(lock_lost), .lock_lost_clr(lock_lost_clr),
    .pll_reset(pll_reset), .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel),
    .pll_odsel(pll_odsel), .pll_lock(pll_lock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit odiv_ok(input int od);
    foreach (valid_od[i]) if (valid_od[i] == od) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int enc_div(input int m1);
    return 63 - m1;
  endfunction

  function automatic int enc_od(input int od);
    return (64 - od / 2) % 64;
  endfunction

  task automatic set_init_model();
    m_idsel    = enc_div(0);
    m_fbdsel   = enc_div(10);
    m_odsel    = enc_od(4);
    m_err_code = 0;
    m_locked   = 0;
  endtask

  // Edges from the reference sample until pll_reset is seen low
  task automatic count_reset_high(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      n++;
      if (!pll_reset) break;
    end
  endtask

  // Called at the sample where pll_reset fell; lock_d < 0 means the PLL never locks
  task automatic lock_phase(input int lock_d);
    bit exp_done;
    int exp_k, ev_k;
    bit got_done, got_err;
    exp_done = (lock_d >= 0) && (lock_d + LOCK_LAT <= TMO);
    exp_k    = exp_done ? lock_d + LOCK_LAT : TMO;
    ev_k     = -1;
    got_done = 1'b0;
    got_err  = 1'b0;
    if (lock_d == 0) pll_lock = 1'b1;
    for (int k = 1; k <= TMO + 20; k++) begin
      step();
      if (done || err) begin
        ev_k = k; got_done = done; got_err = err;
        break;
      end
      if (k == lock_d) pll_lock = 1'b1;
    end
    chk("event_cycle", ev_k, exp_k);
    chk("event_done", int'(got_done), int'(exp_done));
    chk("event_err", int'(got_err), int'(!exp_done));
    if (exp_done) begin
      chk("locked_on_done", int'(locked), 1);
      chk("errcode_on_done", int'(err_code), m_err_code);
      m_locked = 1;
    end else begin
      chk("errcode_timeout", int'(err_code), 2);
      chk("locked_timeout", int'(locked), 0);
      chk("reset_timeout", int'(pll_reset), 0);
      m_locked   = 0;
      m_err_code = 2;
    end
    chk("ready_after_seq", int'(req_ready), 1);
    step();
    chk("pulse_width", int'(done | err), 0);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!req_ready && w < 400) begin
      step();
      w++;
    end
    if (!req_ready) chk("ready_wait", 0, 1);
  endtask

  // One request transaction; returns at the first sample after the request completes
  task automatic do_request(input int idiv, input int fbdiv, input int od, input int lock_d);
    int n;
    wait_ready();
    req_valid    = 1'b1;
    req_idiv_m1  = 6'(idiv);
    req_fbdiv_m1 = 6'(fbdiv);
    req_odiv     = 8'(od);
    step();
    req_valid = 1'b0;
    if (odiv_ok(od)) begin
      m_idsel  = enc_div(idiv);
      m_fbdsel = enc_div(fbdiv);
      m_odsel  = enc_od(od);
      m_err_code = 0;
      m_locked   = 0;
      chk("acc_ready", int'(req_ready), 0);
      chk("acc_reset", int'(pll_reset), 1);
      chk("acc_idsel", int'(pll_idsel), m_idsel);
      chk("acc_fbdsel", int'(pll_fbdsel), m_fbdsel);
      chk("acc_odsel", int'(pll_odsel), m_odsel);
      chk("acc_locked", int'(locked), 0);
      chk("acc_errcode", int'(err_code), 0);
      chk("acc_err", int'(err), 0);
      pll_lock = 1'b0;
      count_reset_high(n);
      chk("reset_len", n, RST_LEN);
      lock_phase(lock_d);
    end else begin
      m_err_code = 1;
      chk("inv_err", int'(err), 1);
      chk("inv_errcode", int'(err_code), 1);
      chk("inv_ready", int'(req_ready), 0);
      chk("inv_reset", int'(pll_reset), 0);
      chk("inv_idsel", int'(pll_idsel), m_idsel);
      chk("inv_fbdsel", int'(pll_fbdsel), m_fbdsel);
      chk("inv_odsel", int'(pll_odsel), m_odsel);
      chk("inv_locked", int'(locked), m_locked);
      step();
      chk("inv_ready_back", int'(req_ready), 1);
      chk("inv_err_pulse", int'(err), 0);
    end
  endtask

  // Single-cycle low glitch on pll_lock; optional clear aligned with the loss
  task automatic glitch(input bit clr_same);
    int seen = -1;
    pll_lock = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) pll_lock = 1'b1;
      if (k == 2 && clr_same) lock_lost_clr = 1'b1;
      if (k == 3) lock_lost_clr = 1'b0;
      if (!locked && seen < 0) seen = k;
    end
    m_locked = 0;
    chk("loss_latency", seen, 3);
    chk("loss_lost", int'(lock_lost), 1);
    chk("loss_locked", int'(locked), 0);
  endtask

  task automatic clear_lost();
    lock_lost_clr = 1'b1;
    step();
    lock_lost_clr = 1'b0;
    chk("lost_cleared", int'(lock_lost), 0);
  endtask

  initial begin
    int n, od, d, r;
    nrst = 1'b0; req_valid = 1'b0; req_idiv_m1 = '0; req_fbdiv_m1 = '0;
    req_odiv = '0; lock_lost_clr = 1'b0; pll_lock = 1'b0;
    set_init_model();
    repeat (3) step();

    // Reset values
    chk("rst_reset", int'(pll_reset), 1);
    chk("rst_idsel", int'(pll_idsel), 63);
    chk("rst_fbdsel", int'(pll_fbdsel), 53);
    chk("rst_odsel", int'(pll_odsel), 62);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_done_err", int'(done | err), 0);
    chk("rst_errcode", int'(err_code), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_lost", int'(lock_lost), 0);

    // Power-up sequence
    nrst = 1'b1;
    count_reset_high(n);
    chk("pwr_reset_len", n, RST_LEN);
    lock_phase(100);

    // Directed requests
    do_request(1, 20, 8, 50);
    do_request(5, 7, 6, 0);
    do_request(2, 3, 16, -1);
    do_request(0, 63, 128, 194);
    do_request(63, 0, 2, 195);
    do_request(9, 9, 64, 0);

    // Lock-loss monitoring
    glitch(1'b0);
    clear_lost();
    do_request(3, 30, 32, 10);
    glitch(1'b1);
    clear_lost();
    do_request(4, 12, 48, 5);

    // Randomized requests
    for (int t = 0; t < 30; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        do od = int'($urandom_range(0, 255)); while (odiv_ok(od));
      end else begin
        od = valid_od[$urandom_range(0, 10)];
      end
      d = ($urandom_range(0, 6) == 0) ? -1 : int'($urandom_range(0, 210));
      do_request(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), od, d);
    end

    // Reset asserted while waiting for lock
    wait_ready();
    req_valid = 1'b1; req_idiv_m1 = 6'd7; req_fbdiv_m1 = 6'd33; req_odiv = 8'd96;
    step();
    req_valid = 1'b0;
    pll_lock  = 1'b0;
    count_reset_high(n);
    chk("abort_reset_len", n, RST_LEN);
    r = 0;
    repeat (30) begin
      step();
      if (done || err) r++;
    end
    nrst = 1'b0;
    #1;
    chk("abort_reset", int'(pll_reset), 1);
    chk("abort_idsel", int'(pll_idsel), 63);
    chk("abort_fbdsel", int'(pll_fbdsel), 53);
    chk("abort_odsel", int'(pll_odsel), 62);
    chk("abort_pulses", r + int'(done) + int'(err), 0);
    set_init_model();
    step();
    nrst = 1'b1;
    count_reset_high(n);
    chk("repwr_reset_len", n, RST_LEN);
    lock_phase(20);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pll_dyn_ctrl.md
Name: pll_dyn_ctrl

Overview:
- Initiator-side controller for the rPLL dynamic-divider interface.
- Drives the PLL's RESET, IDSEL, FBDSEL and ODSEL inputs and watches its LOCK output.
- Accepts new divider settings through a valid/ready request, range-checks them, then runs the reset/apply/relock sequence with a timeout.
- Runs from the PLL input reference clock, so it keeps working while the PLL is unlocked.

Parameters:
- RST_CYCLES, 16: cycles pll_reset is held high per sequence (>=2).
- LOCK_TIMEOUT, 65535: maximum cycles from reset release to qualified lock.
- LOCK_FILTER, 4: consecutive synchronized-high lock samples required to declare lock.
- IDIV_INIT, 0: input divider minus one, used at power-up.
- FBDIV_INIT, 10: feedback divider minus one, used at power-up.
- ODIV_INIT, 4: output divider value, used at power-up.

Ports:
- clk, in, 1: reference clock (PLL input clock).
- nrst, in, 1: asynchronous active-low reset.
- req_valid, in, 1: new-setting request.
- req_ready, out, 1: high only in IDLE.
- req_idiv_m1, in, 6: input divider minus one (0..63).
- req_fbdiv_m1, in, 6: feedback divider minus one (0..63).
- req_odiv, in, 8: output divider value.
- done, out, 1: one-cycle pulse on successful lock.
- err, out, 1: one-cycle pulse on failure.
- err_code, out, 2: 01 = invalid request, 10 = lock timeout; holds until the next request is accepted.
- locked, out, 1: qualified, synchronized lock status.
- lock_lost, out, 1: sticky, set on loss of lock while in IDLE.
- lock_lost_clr, in, 1: clears lock_lost.
- pll_reset, out, 1: to PLL RESET.
- pll_idsel, out, 6: to PLL IDSEL.
- pll_fbdsel, out, 6: to PLL FBDSEL.
- pll_odsel, out, 6: to PLL ODSEL.
- pll_lock, in, 1: PLL LOCK; asynchronous to clk.

Behaviour:
- Reset (nrst low), all outputs:
  - pll_reset = 1.
  - pll_idsel = ~IDIV_INIT, pll_fbdsel = ~FBDIV_INIT, pll_odsel = (64 - ODIV_INIT/2) mod 64.
  - req_ready = 0, done = 0, err = 0, err_code = 00, locked = 0, lock_lost = 0.
  - State = HOLD_RST with counter = 0.
  - Power-up therefore runs a full lock sequence with no request.
- Encoding, registered outputs:
  - idsel = ~idiv_m1, fbdsel = ~fbdiv_m1 (6-bit complement).
  - odsel = (64 - odiv/2) mod 64, so odiv 128 gives 0 and odiv 2 gives 63.
- Valid req_odiv values: {2,4,8,16,32,48,64,80,96,112,128}. Anything else is invalid. Divider-minus-one fields are always valid.
- pll_lock passes through a 2-FF synchronizer before any use. The filter counter saturates at LOCK_FILTER and clears on any low sample.
- IDLE:
  - req_ready = 1. Accept when req_valid && req_ready; ready drops the cycle after acceptance.
  - Invalid request: err pulses the cycle after acceptance with err_code = 01. Selects and pll_reset are untouched. Return to IDLE; ready is high again the following cycle.
  - Valid request: on the cycle after acceptance, the selects update, pll_reset = 1, locked = 0, err_code = 00. Go to HOLD_RST.
- HOLD_RST:
  - pll_reset stays high for exactly RST_CYCLES cycles (counted from its rising edge), then falls.
  - Clear the timeout counter; go to WAIT_LOCK.
- WAIT_LOCK:
  - The timeout counter increments each cycle.
  - Filter reaches LOCK_FILTER: locked = 1, done pulses one cycle, go to IDLE.
  - Counter reaches LOCK_TIMEOUT without lock: err pulses, err_code = 10, locked = 0, pll_reset stays 0, go to IDLE. There is no automatic retry.
  - Lock present and timeout reached on the same cycle: lock wins.
- Lock monitoring in IDLE with locked = 1:
  - A synchronized low sample clears locked and sets lock_lost.
  - No automatic relock; relock is software-driven by re-issuing the request.
  - lock_lost_clr clears lock_lost. If clear and a new loss occur on the same cycle, set wins.
- Requests are ignored (ready = 0) outside IDLE; req_valid may be held across that period.
- nrst asserted mid-sequence aborts immediately to the reset values (INIT selects, pll_reset = 1) and restarts the power-up sequence.
- All counters are sized to their parameter and never wrap: the timeout counter saturates and the filter counter saturates.

Test Plan:
1. Power-up: release nrst, pll_lock rising 100 cycles after pll_reset falls. pll_reset is high for 16 cycles, selects are 63/53/62, locked rises 2+4 cycles after pll_lock, done pulses once, and req_ready then goes high.
2. Valid request idiv_m1 = 1, fbdiv_m1 = 20, odiv = 8 with lock returning after 50 cycles. One cycle after the handshake the outputs read idsel = 62, fbdsel = 43, odsel = 60, and pll_reset is high for 16 cycles. done pulses and err stays 0.
3. Invalid odiv = 6. err pulses the cycle after acceptance with err_code = 01. pll_reset and the selects are unchanged, and req_ready returns 2 cycles after acceptance.
4. Valid request with pll_lock held low, using LOCK_TIMEOUT = 200 in the bench. err pulses exactly 200 cycles after pll_reset falls, with err_code = 10 and locked = 0.
5. Lock glitch while locked: pll_lock low for 1 cycle gives locked = 0 and lock_lost = 1. lock_lost_clr asserted on the same cycle as a new loss leaves lock_lost = 1. A later clr alone gives lock_lost = 0.
6. nrst pulsed low during WAIT_LOCK. pll_reset = 1 immediately and the selects return to their INIT encodings. No done or err pulse is seen, and the full power-up sequence runs again.
